// File: rtl/fg_pkg.sv
// Shared types and limits for the waveform sequencer: signal types, clamp limits,
// the program-entry layout and the sequencer FSM states.
package fg_pkg;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    TRIANGLE = 3'd1,
    SQUARE   = 3'd2,
    PWM      = 3'd3,
    PATTERN  = 3'd4
  } signal_t;

  localparam logic [31:0] SINE_TRI_MAX = 32'd9999;
  localparam logic [31:0] SQ_PWM_MAX   = 32'd499999;
  localparam logic [31:0] PATTERN_MAX  = 32'd62499;
  localparam logic [31:0] RESET_COUNT  = 32'd999;

  // Field order matches the host write word, MSB first.
  typedef struct packed {
    logic [15:0] dwell;
    logic [7:0]  duty;
    logic [31:0] count;
    logic [2:0]  sig;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_DWELL,
    ST_DONE
  } state_t;

  function automatic logic [31:0] count_limit(input logic [2:0] sig);
    case (sig)
      SQUARE, PWM: count_limit = SQ_PWM_MAX;
      PATTERN:     count_limit = PATTERN_MAX;
      default:     count_limit = SINE_TRI_MAX;
    endcase
  endfunction

endpackage

// File: rtl/fg_seq_table.sv
// 8-entry program store: one synchronous write port, combinational read.
// Write lands on the clock edge; no backpressure inside, the caller gates wr_en_i.
module fg_seq_table
  import fg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_addr_i,
  input  logic [58:0] wr_data_i,
  input  logic [2:0]  rd_addr_i,
  output logic [58:0] rd_data_o
);

  entry_t mem_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= entry_t'(wr_data_i);
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fg_sequencer.sv
// Steps through a programmed list of waveform settings, clamping counts and dwelling per entry.
// Outputs update 2 cycles after start; host writes are held off (wr_ready=0) while running.
module fg_sequencer
  import fg_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [58:0] wr_data,
  input  logic [3:0]  num_entries,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [2:0]  sig_type_o,
  output logic [31:0] set_count_o,
  output logic [7:0]  duty_cycle_o,
  output logic        cfg_update,
  output logic        busy,
  output logic        done,
  output logic [2:0]  cur_idx,
  output logic        err
);

  localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [23:0] presc_q;
  logic [15:0] dwell_q;
  logic [2:0]  sig_q;
  logic [31:0] count_q;
  logic [7:0]  duty_q;
  logic        cfg_update_q;
  logic        err_q;

  logic [58:0] rd_data;
  entry_t      ent;
  logic [31:0] limit;
  logic        over_limit;
  logic        type_bad;
  logic [15:0] dwell_tgt;
  logic        last_entry;
  logic        num_bad;
  state_t      adv_state;
  logic [2:0]  adv_idx;

  fg_seq_table u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_valid && wr_ready),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  // The table cannot change while running, so LOAD, APPLY and DWELL all read it live.
  assign ent        = entry_t'(rd_data);
  assign limit      = count_limit(ent.sig);
  assign over_limit = ent.count > limit;
  assign type_bad   = ent.sig > 3'd4;
  assign dwell_tgt  = (ent.dwell == 16'd0) ? 16'd1 : ent.dwell;
  assign num_bad    = (num_entries == 4'd0) || (num_entries > 4'd8);
  assign last_entry = ({1'b0, idx_q} + 4'd1) >= num_entries;
  assign adv_state  = (last_entry && !loop_en) ? ST_DONE : ST_LOAD;
  assign adv_idx    = last_entry ? (loop_en ? 3'd0 : idx_q) : idx_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      presc_q      <= '0;
      dwell_q      <= '0;
      sig_q        <= SINE;
      count_q      <= RESET_COUNT;
      duty_q       <= 8'd0;
      cfg_update_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              if (num_bad) begin
                err_q <= 1'b1;
              end else begin
                err_q   <= 1'b0;
                idx_q   <= 3'd0;
                state_q <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            if (type_bad) begin
              err_q   <= 1'b1;
              idx_q   <= adv_idx;
              state_q <= adv_state;
            end else begin
              if (over_limit) err_q <= 1'b1;
              state_q <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            sig_q        <= ent.sig;
            count_q      <= over_limit ? limit : ent.count;
            duty_q       <= ent.duty;
            cfg_update_q <= 1'b1;
            presc_q      <= '0;
            dwell_q      <= '0;
            state_q      <= ST_DWELL;
          end
          ST_DWELL: begin
            if (presc_q == PRESC_MAX) begin
              presc_q <= '0;
              if (dwell_q + 16'd1 == dwell_tgt) begin
                idx_q   <= adv_idx;
                state_q <= adv_state;
              end else begin
                dwell_q <= dwell_q + 16'd1;
              end
            end else begin
              presc_q <= presc_q + 24'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_APPLY) || (state_q == ST_DWELL);
  assign done         = (state_q == ST_DONE);
  assign cur_idx      = idx_q;
  assign err          = err_q;
  assign cfg_update   = cfg_update_q;
  assign sig_type_o   = sig_q;
  assign set_count_o  = count_q;
  assign duty_cycle_o = duty_q;

endmodule

// File: tb/tb_fg_sequencer.sv
// Directed bench for fg_sequencer with TICK_DIV=4: vector table of single-entry runs
// plus hand sequences for timing, skip, loop/stop, write handshake and reset.
module tb_fg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [58:0] wr_data = '0;
  logic [3:0]  num_entries = 4'd1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [2:0]  sig_type_o;
  logic [31:0] set_count_o;
  logic [7:0]  duty_cycle_o;
  logic        cfg_update;
  logic        busy;
  logic        done;
  logic [2:0]  cur_idx;
  logic        err;

  int tests = 0;
  int fails = 0;

  fg_sequencer #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .num_entries  (num_entries),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .sig_type_o   (sig_type_o),
    .set_count_o  (set_count_o),
    .duty_cycle_o (duty_cycle_o),
    .cfg_update   (cfg_update),
    .busy         (busy),
    .done         (done),
    .cur_idx      (cur_idx),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sig;
    logic [31:0] count;
    logic [7:0]  duty;
    logic [2:0]  exp_sig;
    logic [31:0] exp_count;
    logic [7:0]  exp_duty;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [58:0] mk(input logic [2:0] t, input logic [31:0] c,
                                      input logic [7:0] d, input logic [15:0] dw);
    return {dw, d, c, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [58:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    vecs[0] = '{3'd2, 32'd1000,   8'd0,   3'd2, 32'd1000,   8'd0,   1'b0};
    vecs[1] = '{3'd3, 32'd500,    8'd64,  3'd3, 32'd500,    8'd64,  1'b0};
    vecs[2] = '{3'd0, 32'd20000,  8'd10,  3'd0, 32'd9999,   8'd10,  1'b1};
    vecs[3] = '{3'd4, 32'd70000,  8'd1,   3'd4, 32'd62499,  8'd1,   1'b1};
    vecs[4] = '{3'd1, 32'd9999,   8'd2,   3'd1, 32'd9999,   8'd2,   1'b0};
    vecs[5] = '{3'd1, 32'd10000,  8'd3,   3'd1, 32'd9999,   8'd3,   1'b1};
    vecs[6] = '{3'd2, 32'd499999, 8'd4,   3'd2, 32'd499999, 8'd4,   1'b0};
    vecs[7] = '{3'd3, 32'd500000, 8'd5,   3'd3, 32'd499999, 8'd5,   1'b1};
    vecs[8] = '{3'd4, 32'd62499,  8'd6,   3'd4, 32'd62499,  8'd6,   1'b0};
    vecs[9] = '{3'd0, 32'd0,      8'd255, 3'd0, 32'd0,      8'd255, 1'b0};

    #12 rst_n = 1'b1;
    tick();
    chk("rst_sig", sig_type_o, 0);
    chk("rst_count", set_count_o, 999);
    chk("rst_duty", duty_cycle_o, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_ready", wr_ready, 1);

    // Single-entry runs, including clamp boundaries on each side of every limit
    num_entries = 4'd1;
    for (int i = 0; i < 10; i++) begin
      write_entry(3'd0, mk(vecs[i].sig, vecs[i].count, vecs[i].duty, 16'd1));
      pulse_start();
      tick();
      tick();
      chk($sformatf("v%0d_cfg_update", i), cfg_update, 1);
      chk($sformatf("v%0d_sig", i), sig_type_o, vecs[i].exp_sig);
      chk($sformatf("v%0d_count", i), set_count_o, vecs[i].exp_count);
      chk($sformatf("v%0d_duty", i), duty_cycle_o, vecs[i].exp_duty);
      wait_done();
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
    end

    // Basic two-entry timing
    write_entry(3'd0, mk(3'd2, 32'd1000, 8'd0, 16'd2));
    write_entry(3'd1, mk(3'd3, 32'd500, 8'd64, 16'd1));
    num_entries = 4'd2;
    pulse_start();
    chk("basic_busy_load", busy, 1);
    tick();
    chk("basic_no_early_update", cfg_update, 0);
    tick();
    chk("basic_upd0", cfg_update, 1);
    chk("basic_sig0", sig_type_o, 2);
    chk("basic_count0", set_count_o, 1000);
    chk("basic_duty0", duty_cycle_o, 0);
    chk("basic_wr_ready_run", wr_ready, 0);
    for (int k = 0; k < 9; k++) tick();
    chk("basic_upd1_not_yet", cfg_update, 0);
    tick();
    chk("basic_upd1", cfg_update, 1);
    chk("basic_sig1", sig_type_o, 3);
    chk("basic_count1", set_count_o, 500);
    chk("basic_duty1", duty_cycle_o, 64);
    chk("basic_idx1", cur_idx, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("basic_done_not_yet", done, 0);
    tick();
    chk("basic_done", done, 1);
    chk("basic_busy_done", busy, 0);
    chk("basic_err", err, 0);

    // Invalid type at entry 0 is skipped in one cycle
    write_entry(3'd0, mk(3'd6, 32'd100, 8'd7, 16'd1));
    write_entry(3'd1, mk(3'd0, 32'd300, 8'd5, 16'd1));
    pulse_start();
    tick();
    chk("skip_no_upd_a", cfg_update, 0);
    tick();
    chk("skip_no_upd_b", cfg_update, 0);
    chk("skip_idx", cur_idx, 1);
    tick();
    chk("skip_upd", cfg_update, 1);
    chk("skip_count", set_count_o, 300);
    chk("skip_duty", duty_cycle_o, 5);
    chk("skip_err", err, 1);
    wait_done();

    // Looping, then stop mid-dwell
    begin
      logic [2:0] seen [4];
      int k = 0;
      int n = 0;
      for (int j = 0; j < 4; j++) seen[j] = 3'd7;
      write_entry(3'd0, mk(3'd2, 32'd1000, 8'd0, 16'd1));
      write_entry(3'd1, mk(3'd3, 32'd500, 8'd64, 16'd1));
      loop_en = 1'b1;
      pulse_start();
      while (k < 4 && n < 100) begin
        tick();
        n++;
        if (cfg_update) begin
          seen[k] = cur_idx;
          k++;
        end
      end
      chk("loop_idx0", seen[0], 0);
      chk("loop_idx1", seen[1], 1);
      chk("loop_idx2", seen[2], 0);
      chk("loop_idx3", seen[3], 1);
      tick();
      tick();
      chk("loop_busy_pre_stop", busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_no_upd", cfg_update, 0);
      chk("stop_sig", sig_type_o, 3);
      chk("stop_count", set_count_o, 500);
      chk("stop_duty", duty_cycle_o, 64);
      chk("stop_wr_ready", wr_ready, 1);
      tick();
      tick();
      chk("stop_stays_idle", busy, 0);
      loop_en = 1'b0;
    end

    // Writes are refused while running, accepted after DONE
    num_entries = 4'd1;
    write_entry(3'd0, mk(3'd2, 32'd1000, 8'd0, 16'd1));
    pulse_start();
    tick();
    chk("hs_wr_ready_busy", wr_ready, 0);
    write_entry(3'd0, mk(3'd3, 32'd777, 8'd9, 16'd1));
    wait_done();
    pulse_start();
    tick();
    tick();
    chk("hs_blocked_sig", sig_type_o, 2);
    chk("hs_blocked_count", set_count_o, 1000);
    wait_done();
    chk("hs_wr_ready_done", wr_ready, 1);
    write_entry(3'd0, mk(3'd3, 32'd777, 8'd9, 16'd1));
    pulse_start();
    tick();
    tick();
    chk("hs_new_sig", sig_type_o, 3);
    chk("hs_new_count", set_count_o, 777);
    chk("hs_new_duty", duty_cycle_o, 9);
    wait_done();

    // Illegal program lengths
    num_entries = 4'd0;
    pulse_start();
    chk("num0_err", err, 1);
    chk("num0_busy", busy, 0);
    tick();
    chk("num0_stays", busy, 0);
    chk("num0_no_upd", cfg_update, 0);
    num_entries = 4'd9;
    pulse_start();
    chk("num9_err", err, 1);
    chk("num9_busy", busy, 0);

    // Asynchronous reset mid-dwell
    num_entries = 4'd1;
    write_entry(3'd0, mk(3'd4, 32'd1234, 8'd77, 16'd5));
    pulse_start();
    for (int k = 0; k < 5; k++) tick();
    chk("arst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sig", sig_type_o, 0);
    chk("arst_count", set_count_o, 999);
    chk("arst_duty", duty_cycle_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", cur_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
